// File: rtl/half_adder_pkg.sv
// half_adder_pkg: shared result type and single-lane half-add evaluation
package half_adder_pkg;
  typedef struct packed {
    logic carry;
    logic sum;
  } ha_res_t;
  function automatic ha_res_t ha_eval(input logic a, input logic b);
    return '{carry: a & b, sum: a ^ b};
  endfunction
endpackage

// File: rtl/half_adder_cell.sv
// half_adder_cell: one combinational half-adder lane
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  ha_res_t res;
  always_comb res = ha_eval(a_i, b_i);
  assign sum_o   = res.sum;
  assign carry_o = res.carry;
endmodule

// File: rtl/half_adder.sv
// half_adder: WIDTH-lane half adder with qualified output register and saturating carry counter
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);
  logic [WIDTH-1:0] sum_d, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    half_adder_cell u_cell (
      .a_i(a[g]),
      .b_i(b[g]),
      .sum_o(sum[g]),
      .carry_o(carry[g])
    );
  end
  always_comb begin
    sum_d   = in_valid ? sum : sum_q;
    carry_d = in_valid ? carry : carry_q;
    cnt_d   = (in_valid && |carry && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= '0;
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      out_valid <= in_valid;
      cnt_q     <= cnt_d;
    end
  end
  assign carry_cnt = cnt_q;
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: vector table plus scoreboard checks on a 1-lane and a 4-lane instance
module tb_half_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
  logic s1, c1, sq1, cq1, ov1;
  logic [1:0] cnt1;
  logic [3:0] a4 = '0, b4 = '0;
  logic v4 = 1'b0;
  logic [3:0] s4, c4, sq4, cq4;
  logic ov4;
  logic [7:0] cnt4;
  int total = 0, bad = 0;
  logic [1:0] sb[$];
  logic [1:0] exp_r = '0;
  int cnt_m = 0;

  typedef struct {
    logic a;
    logic b;
    logic [1:0] cs;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .CNT_W(2)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1),
    .out_valid(ov1), .carry_cnt(cnt1)
  );

  half_adder #(.WIDTH(4), .CNT_W(8)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4),
    .sum(s4), .carry(c4), .sum_q(sq4), .carry_q(cq4),
    .out_valid(ov4), .carry_cnt(cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic ai, input logic bi, input logic vi, input logic [1:0] cs);
    @(negedge clk);
    a1 = ai;
    b1 = bi;
    v1 = vi;
    if (vi) sb.push_back(cs);
    #1 chk("comb", {c1, s1}, cs);
    @(posedge clk);
    #1;
    if (vi && ai && bi && cnt_m != 3) cnt_m++;
    chk("out_valid", ov1, vi);
    if (ov1) begin
      if (sb.size() > 0) exp_r = sb.pop_front();
      else begin
        total++;
        bad++;
        $display("FAIL sb_underflow: out_valid with no pending result at %0t", $time);
      end
    end
    chk("regs", {cq1, sq1}, exp_r);
    chk("carry_cnt", cnt1, cnt_m);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_regs", {cq1, sq1}, 2'b00);
    chk("rst_out_valid", ov1, 1'b0);
    chk("rst_cnt", cnt1, 0);
    chk("rst_w4_regs", {cq4, sq4}, 8'h00);
    chk("rst_w4_cnt", {ov4, cnt4}, 9'h000);
    a1 = 1'b0;
    b1 = 1'b1;
    #1 chk("rst_comb01", {c1, s1}, 2'b01);
    a1 = 1'b1;
    #1 chk("rst_comb11", {c1, s1}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1'b0;
    sb.delete();
    exp_r = '0;
    cnt_m = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 2'b00};
    tbl[1] = '{1'b0, 1'b1, 2'b01};
    tbl[2] = '{1'b1, 1'b0, 2'b01};
    tbl[3] = '{1'b1, 1'b1, 2'b10};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_regs", {cq1, sq1}, 2'b00);
    chk("reset_valid_cnt", {ov1, cnt1}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    // comb sweep without qualification: registers must stay at reset values
    for (int i = 0; i < 4; i++) step(tbl[i].a, tbl[i].b, 1'b0, tbl[i].cs);
    for (int i = 0; i < 4; i++) step(tbl[i].a, tbl[i].b, 1'b1, tbl[i].cs);
    step(1'b1, 1'b1, 1'b0, 2'b10);
    step(1'b0, 1'b1, 1'b0, 2'b01);
    async_reset();
    step(1'b1, 1'b1, 1'b1, 2'b10);
    step(1'b1, 1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b1, 1'b1, 2'b10);
    step(1'b0, 1'b0, 1'b0, 2'b00);
    async_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 2'b10);
    @(negedge clk);
    a4 = 4'b1010;
    b4 = 4'b0110;
    v4 = 1'b1;
    #1;
    chk("w4_sum", s4, 4'b1100);
    chk("w4_carry", c4, 4'b0010);
    @(posedge clk);
    #1;
    chk("w4_sum_q", sq4, 4'b1100);
    chk("w4_carry_q", cq4, 4'b0010);
    chk("w4_valid_cnt", {ov4, cnt4}, 9'h101);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      @(negedge clk);
      a4 = ra;
      b4 = rb;
      v4 = 1'b0;
      #1;
      for (int j = 0; j < 4; j++) begin
        logic [1:0] e;
        e = {1'b0, ra[j]} + {1'b0, rb[j]};
        chk($sformatf("w4_lane%0d", j), {c4[j], s4[j]}, e);
      end
    end
    @(posedge clk);
    #1;
    chk("w4_hold_sum_q", sq4, 4'b1100);
    chk("w4_hold_valid_cnt", {ov4, cnt4}, 9'h001);
    async_reset();
    step(1'b0, 1'b1, 1'b1, 2'b01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
Parameters:
REQ-001 WIDTH, default 1, number of independent 1-bit half-adder lanes.
REQ-002 CNT_W, default 8, width of the carry-event counter.
Ports:
REQ-003 clk  input  1  single clock; all sequential logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a  input  WIDTH  addend A, one bit per lane.
REQ-006 b  input  WIDTH  addend B, one bit per lane.
REQ-007 in_valid  input  1  qualifies a/b for registered path and counter.
REQ-008 sum  output  WIDTH  combinational sum, a XOR b per lane.
REQ-009 carry  output  WIDTH  combinational carry, a AND b per lane.
REQ-010 sum_q  output  WIDTH  registered sum.
REQ-011 carry_q  output  WIDTH  registered carry.
REQ-012 out_valid  output  1  registered in_valid.
REQ-013 carry_cnt  output  CNT_W  count of accepted cycles with any carry set.

Function
REQ-014 sum and carry SHALL be purely combinational, zero latency, independent of clk, rst_n and in_valid.
REQ-015 Per lane i: sum[i] = a[i] XOR b[i], carry[i] = a[i] AND b[i]; lanes SHALL NOT interact.
REQ-016 For each lane, {carry, sum} SHALL equal a + b as a 2-bit value: 00->00, 01->01, 10->01, 11->10.
REQ-017 On a rising clk edge with in_valid=1, sum_q/carry_q SHALL load the current sum/carry (latency 1 cycle).
REQ-018 On a rising clk edge with in_valid=0, sum_q/carry_q SHALL hold their previous values.
REQ-019 out_valid SHALL equal in_valid delayed by one clk cycle, every cycle.
REQ-020 carry_cnt SHALL increment by 1 on an edge where in_valid=1 and any carry bit is 1.
REQ-021 carry_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-022 X/Z on inputs while in_valid=0 SHALL NOT affect sum_q, carry_q or carry_cnt.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force sum_q=0, carry_q=0, out_valid=0, carry_cnt=0.
REQ-024 Combinational sum/carry SHALL remain functional during reset.
REQ-025 The first edge after rst_n deasserts SHALL behave as a normal edge, per REQ-017..REQ-021.
REQ-026 Reset asserted mid-operation SHALL discard the pending registered result and counter value.

Structure
REQ-027 No shared package is required; WIDTH and CNT_W are module parameters only.
REQ-028 One sub-module half_adder_cell (1-bit a, b -> sum, carry, combinational), instantiated WIDTH times.
REQ-029 Register stage and saturating counter SHALL reside in half_adder itself.

Verification
REQ-030 WIDTH=1, in_valid=0, sweep {a,b}=00,01,10,11 each time step -> {carry,sum}=00,01,01,10 with no clock dependence.
REQ-031 Same sweep with in_valid=1 -> sum_q/carry_q match the previous cycle's comb values; out_valid high one cycle after in_valid.
REQ-032 in_valid toggled 1,0,1 with a=b=1 on all cycles -> carry_cnt steps 0,1,1,2; sum_q/carry_q hold during the 0 cycle.
REQ-033 CNT_W=2, a=b=1, in_valid=1 for 6 cycles -> carry_cnt sequence 1,2,3,3,3,3.
REQ-034 Assert rst_n=0 between clk edges -> sum_q, carry_q, out_valid, carry_cnt go to 0 immediately; sum/carry still track a/b.
REQ-035 WIDTH=4, a=4'b1010, b=4'b0110 -> sum=4'b1100, carry=4'b0010, lanes independent.
